// File: rtl/bp_common_pkg.sv
// Shared backend types: write-buffer drain controller states and data-mem port owner encoding.
package bp_common_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StForce = 2'd1,
    StFence = 2'd2
  } bp_be_dcache_wbuf_ctrl_state_e;

  typedef enum logic [1:0] {
    DmemNone = 2'd0,
    DmemLoad = 2'd1,
    DmemLce  = 2'd2,
    DmemWbuf = 2'd3
  } bp_be_dcache_dmem_sel_e;

endpackage

// File: rtl/bp_be_dcache_wbuf_starve_ctr.sv
// Saturating up-counter with synchronous clear and an at-limit flag.
module bp_be_dcache_wbuf_starve_ctr #(
  parameter int unsigned        width_p = 4,
  parameter logic [width_p-1:0] limit_p = '1
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clr_i,
  input  logic               inc_i,
  output logic [width_p-1:0] count_o,
  output logic               at_limit_o
);

  logic [width_p-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != limit_p)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o    = count_q;
  assign at_limit_o = (count_q == limit_p);

endmodule

// File: rtl/bp_be_dcache_wbuf_ctrl.sv
// D$ write-buffer drain scheduler and data-mem port arbiter.
// Optional performance counters: define BP_BE_DCACHE_WBUF_CTRL_PERF_EN.
module bp_be_dcache_wbuf_ctrl
  import bp_common_pkg::*;
#(
  parameter int unsigned starve_limit_p = 8,
  parameter int unsigned ctr_width_p    = 32
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   wbuf_v_i,
  input  logic                   wbuf_empty_i,
  output logic                   wbuf_yumi_o,
  input  logic                   lce_snoop_match_i,
  input  logic                   lce_data_mem_v_i,
  output logic                   lce_data_mem_yumi_o,
  input  logic                   load_v_i,
  output logic                   load_grant_o,
  output logic                   stall_o,
  input  logic                   fence_v_i,
  output logic                   fence_done_o,
  output logic [1:0]             data_mem_sel_o,
  output logic [ctr_width_p-1:0] drain_ctr_o,
  output logic [ctr_width_p-1:0] force_ctr_o
);

  localparam int unsigned StarveW = $clog2(starve_limit_p + 1);

  bp_be_dcache_wbuf_ctrl_state_e state_q, state_d;
  bp_be_dcache_dmem_sel_e        sel;

  logic               lce_ok;
  logic               snoop_esc;
  logic               yumi;
  logic               load_grant;
  logic               lce_grant;
  logic               fence_done;
  logic               stall;
  logic               starve_at_limit;
  logic [StarveW-1:0] starve_cnt;

  assign lce_ok    = lce_data_mem_v_i & ~lce_snoop_match_i;
  assign snoop_esc = lce_snoop_match_i & lce_data_mem_v_i;

  always_comb begin
    sel = DmemNone;
    if (state_q == StIdle) begin
      if (lce_ok)        sel = DmemLce;
      else if (load_v_i) sel = DmemLoad;
      else if (wbuf_v_i) sel = DmemWbuf;
    end else begin
      if (wbuf_v_i)      sel = DmemWbuf;
      else if (lce_ok)   sel = DmemLce;
      else if (load_v_i) sel = DmemLoad;
    end
  end

  assign yumi       = (sel == DmemWbuf);
  assign load_grant = (sel == DmemLoad);
  assign lce_grant  = (sel == DmemLce);
  assign fence_done = (state_q == StFence) & wbuf_empty_i & ~wbuf_v_i;
  assign stall      = (state_q == StFence) | (load_v_i & ~load_grant) | fence_v_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (fence_v_i)                         state_d = StFence;
        else if (starve_at_limit || snoop_esc) state_d = StForce;
      end
      StForce: begin
        if (fence_v_i)                                 state_d = StFence;
        else if (wbuf_empty_i || (yumi && !snoop_esc)) state_d = StIdle;
      end
      StFence: begin
        if (fence_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  bp_be_dcache_wbuf_starve_ctr #(
    .width_p (StarveW),
    .limit_p (StarveW'(starve_limit_p))
  ) u_starve_ctr (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .clr_i      (yumi | ~wbuf_v_i),
    .inc_i      (wbuf_v_i & ~yumi),
    .count_o    (starve_cnt),
    .at_limit_o (starve_at_limit)
  );

  // Outputs are held low while reset is asserted, even though grants are combinational.
  assign wbuf_yumi_o         = reset_n_i & yumi;
  assign load_grant_o        = reset_n_i & load_grant;
  assign lce_data_mem_yumi_o = reset_n_i & lce_grant;
  assign fence_done_o        = reset_n_i & fence_done;
  assign stall_o             = reset_n_i & stall;
  assign data_mem_sel_o      = reset_n_i ? sel : DmemNone;

`ifdef BP_BE_DCACHE_WBUF_CTRL_PERF_EN
  logic drain_at_limit, force_at_limit;

  bp_be_dcache_wbuf_starve_ctr #(
    .width_p (ctr_width_p),
    .limit_p ({ctr_width_p{1'b1}})
  ) u_drain_ctr (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .clr_i      (1'b0),
    .inc_i      (yumi),
    .count_o    (drain_ctr_o),
    .at_limit_o (drain_at_limit)
  );

  bp_be_dcache_wbuf_starve_ctr #(
    .width_p (ctr_width_p),
    .limit_p ({ctr_width_p{1'b1}})
  ) u_force_ctr (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .clr_i      (1'b0),
    .inc_i      (state_q != StIdle),
    .count_o    (force_ctr_o),
    .at_limit_o (force_at_limit)
  );
`else
  assign drain_ctr_o = '0;
  assign force_ctr_o = '0;
`endif

endmodule

// File: tb/tb_bp_be_dcache_wbuf_ctrl.sv
// Directed self-checking bench for bp_be_dcache_wbuf_ctrl.
module tb_bp_be_dcache_wbuf_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wbuf_v, wbuf_empty, wbuf_yumi;
  logic        snoop, lce_v, lce_yumi;
  logic        load_v, load_grant, stall;
  logic        fence_v, fence_done;
  logic [1:0]  sel;
  logic [31:0] drain_ctr, force_ctr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bp_be_dcache_wbuf_ctrl #(
    .starve_limit_p (8),
    .ctr_width_p    (32)
  ) dut (
    .clk_i               (clk),
    .reset_n_i           (reset_n),
    .wbuf_v_i            (wbuf_v),
    .wbuf_empty_i        (wbuf_empty),
    .wbuf_yumi_o         (wbuf_yumi),
    .lce_snoop_match_i   (snoop),
    .lce_data_mem_v_i    (lce_v),
    .lce_data_mem_yumi_o (lce_yumi),
    .load_v_i            (load_v),
    .load_grant_o        (load_grant),
    .stall_o             (stall),
    .fence_v_i           (fence_v),
    .fence_done_o        (fence_done),
    .data_mem_sel_o      (sel),
    .drain_ctr_o         (drain_ctr),
    .force_ctr_o         (force_ctr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wbuf_v = 0; wbuf_empty = 1; snoop = 0; lce_v = 0; load_v = 0; fence_v = 0;
  endtask

  // Leaves the bench 1 time unit after an edge, out of reset, with idle inputs.
  task automatic do_reset();
    idle_inputs();
    reset_n = 0;
    tick();
    tick();
    reset_n = 1;
  endtask

  task automatic test_reset();
    reset_n = 1;
    idle_inputs();
    #2;
    wbuf_v = 1; wbuf_empty = 0; load_v = 1; lce_v = 1;
    reset_n = 0;
    #1;
    n_checks++;
    if ({wbuf_yumi, load_grant, lce_yumi, stall, fence_done} !== 5'b0) begin
      $display("FAIL reset_grants: got %b want 00000",
               {wbuf_yumi, load_grant, lce_yumi, stall, fence_done});
      n_fail++;
    end
    n_checks++;
    if (sel !== 2'd0) begin
      $display("FAIL reset_sel: got %0d want 0", sel); n_fail++;
    end
    n_checks++;
    if (drain_ctr !== 32'd0 || force_ctr !== 32'd0) begin
      $display("FAIL reset_ctrs: got %0d/%0d want 0/0", drain_ctr, force_ctr); n_fail++;
    end
    do_reset();
  endtask

  task automatic test_opportunistic();
    do_reset();
    wbuf_v = 1; wbuf_empty = 0; load_v = 1;
    for (int c = 0; c < 7; c++) begin
      #1;
      n_checks++;
      if (wbuf_yumi !== 1'b0 || load_grant !== 1'b1) begin
        $display("FAIL opp_load_cycle%0d: yumi=%b grant=%b want 0/1", c, wbuf_yumi, load_grant);
        n_fail++;
      end
      tick();
    end
    load_v = 0;
    #1;
    n_checks++;
    if (wbuf_yumi !== 1'b1 || sel !== 2'd3) begin
      $display("FAIL opp_drain: yumi=%b sel=%0d want 1/3", wbuf_yumi, sel); n_fail++;
    end
    tick();
    load_v = 1;
    #1;
    n_checks++;
    if (load_grant !== 1'b1 || wbuf_yumi !== 1'b0) begin
      $display("FAIL opp_no_force: grant=%b yumi=%b want 1/0", load_grant, wbuf_yumi); n_fail++;
    end
  endtask

  task automatic test_starvation();
    int early;
    do_reset();
    wbuf_v = 1; wbuf_empty = 0; load_v = 1;
    early = 0;
    // Count reaches 8 in cycle 8; FORCE takes effect in cycle 9.
    for (int c = 0; c < 9; c++) begin
      #1;
      if (wbuf_yumi !== 1'b0) early++;
      tick();
    end
    n_checks++;
    if (early != 0) begin
      $display("FAIL starve_early_yumi: got %0d yumis want 0", early); n_fail++;
    end
    #1;
    n_checks++;
    if (wbuf_yumi !== 1'b1 || stall !== 1'b1 || sel !== 2'd3) begin
      $display("FAIL starve_force: yumi=%b stall=%b sel=%0d want 1/1/3", wbuf_yumi, stall, sel);
      n_fail++;
    end
    tick();
    #1;
    n_checks++;
    if (load_grant !== 1'b1 || wbuf_yumi !== 1'b0) begin
      $display("FAIL starve_back_idle: grant=%b yumi=%b want 1/0", load_grant, wbuf_yumi);
      n_fail++;
    end
  endtask

  task automatic test_snoop_block();
    do_reset();
    // Incoming store passthrough with an empty buffer still blocks the LCE.
    wbuf_v = 1; wbuf_empty = 1; snoop = 1; lce_v = 1;
    #1;
    n_checks++;
    if (lce_yumi !== 1'b0 || wbuf_yumi !== 1'b1) begin
      $display("FAIL snoop_passthru: lce=%b yumi=%b want 0/1", lce_yumi, wbuf_yumi); n_fail++;
    end
    do_reset();
    wbuf_v = 1; wbuf_empty = 0; snoop = 1; lce_v = 1;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++;
      if (lce_yumi !== 1'b0 || wbuf_yumi !== 1'b1) begin
        $display("FAIL snoop_drain%0d: lce=%b yumi=%b want 0/1", c, lce_yumi, wbuf_yumi);
        n_fail++;
      end
      tick();
    end
    wbuf_v = 0; wbuf_empty = 1; snoop = 0;
    #1;
    n_checks++;
    if (lce_yumi !== 1'b1 || sel !== 2'd2) begin
      $display("FAIL snoop_release: lce=%b sel=%0d want 1/2", lce_yumi, sel); n_fail++;
    end
  endtask

  task automatic test_fence();
    int pulses, yumis, nostall;
    do_reset();
    fence_v = 1; wbuf_v = 1; wbuf_empty = 0;
    pulses = 0; yumis = 0; nostall = 0;
    // Cycle 0 IDLE drains entry 1, cycle 1 FENCE drains entry 2, cycle 2 completes.
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin wbuf_v = 0; wbuf_empty = 1; end
      #1;
      if (wbuf_yumi === 1'b1) yumis++;
      if (fence_done === 1'b1) pulses++;
      if (stall !== 1'b1) nostall++;
      tick();
      if (c == 2) fence_v = 0;
    end
    n_checks++;
    if (yumis != 2) begin
      $display("FAIL fence_yumis: got %0d want 2", yumis); n_fail++;
    end
    n_checks++;
    if (pulses != 1) begin
      $display("FAIL fence_done_pulses: got %0d want 1", pulses); n_fail++;
    end
    n_checks++;
    if (nostall != 0) begin
      $display("FAIL fence_stall: got %0d unstalled cycles want 0", nostall); n_fail++;
    end
    wbuf_v = 1; wbuf_empty = 0; load_v = 1;
    #1;
    n_checks++;
    if (load_grant !== 1'b1 || stall !== 1'b0 || fence_done !== 1'b0) begin
      $display("FAIL fence_to_idle: grant=%b stall=%b done=%b want 1/0/0",
               load_grant, stall, fence_done);
      n_fail++;
    end
    // Fence on an already-empty buffer completes in the first FENCE cycle.
    do_reset();
    fence_v = 1;
    tick();
    #1;
    n_checks++;
    if (fence_done !== 1'b1 || stall !== 1'b1) begin
      $display("FAIL fence_empty: done=%b stall=%b want 1/1", fence_done, stall); n_fail++;
    end
    tick();
    fence_v = 0;
  endtask

  task automatic test_async_reset();
    do_reset();
    wbuf_v = 1; wbuf_empty = 0; snoop = 1; lce_v = 1; load_v = 1;
    tick();
    #1;
    n_checks++;
    if (wbuf_yumi !== 1'b1 || stall !== 1'b1) begin
      $display("FAIL areset_in_force: yumi=%b stall=%b want 1/1", wbuf_yumi, stall); n_fail++;
    end
    #2;
    reset_n = 0;
    #1;
    n_checks++;
    if ({wbuf_yumi, load_grant, lce_yumi, stall} !== 4'b0 || sel !== 2'd0) begin
      $display("FAIL areset_outputs: got %b sel=%0d want 0000 sel=0",
               {wbuf_yumi, load_grant, lce_yumi, stall}, sel);
      n_fail++;
    end
    tick();
    reset_n = 1;
    snoop = 0; lce_v = 0;
    #1;
    n_checks++;
    if (load_grant !== 1'b1 || wbuf_yumi !== 1'b0) begin
      $display("FAIL areset_idle: grant=%b yumi=%b want 1/0", load_grant, wbuf_yumi); n_fail++;
    end
    n_checks++;
    if (drain_ctr !== 32'd0 || force_ctr !== 32'd0) begin
      $display("FAIL areset_ctrs: got %0d/%0d want 0/0", drain_ctr, force_ctr); n_fail++;
    end
  endtask

  task automatic test_perf_counters();
    logic [31:0] exp_drain, exp_force;
`ifdef BP_BE_DCACHE_WBUF_CTRL_PERF_EN
    exp_drain = 32'd5; exp_force = 32'd3;
`else
    exp_drain = 32'd0; exp_force = 32'd0;
`endif
    do_reset();
    wbuf_v = 1; wbuf_empty = 0;
    tick();
    tick();
    snoop = 1; lce_v = 1;
    tick();  // IDLE drain, escalates
    tick();  // FORCE drain
    tick();  // FORCE drain
    wbuf_v = 0; wbuf_empty = 1;
    tick();  // FORCE, empty -> IDLE
    idle_inputs();
    #1;
    n_checks++;
    if (drain_ctr !== exp_drain) begin
      $display("FAIL perf_drain: got %0d want %0d", drain_ctr, exp_drain); n_fail++;
    end
    n_checks++;
    if (force_ctr !== exp_force) begin
      $display("FAIL perf_force: got %0d want %0d", force_ctr, exp_force); n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_opportunistic();
    test_starvation();
    test_snoop_block();
    test_fence();
    test_async_reset();
    test_perf_counters();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
